// File: rtl/tm_sequencer.sv
// Table-driven Turing-machine sequencer: looks up {state, symbol},
// issues a write/move request to the tape, and tracks step count.
module tm_sequencer #(
  parameter int STATE_W     = 3,
  parameter int SYM_W       = 3,
  parameter int START_STATE = 0,
  parameter int MAX_STEPS   = 255,
  localparam int CNT_W   = $clog2(MAX_STEPS + 1),
  localparam int ADDR_W  = STATE_W + SYM_W,
  localparam int ENTRY_W = STATE_W + SYM_W + 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [ENTRY_W-1:0] cfg_data,
  input  logic               rd_valid,
  input  logic [SYM_W-1:0]   rd_sym,
  output logic               wr_valid,
  output logic [SYM_W-1:0]   wr_sym,
  output logic               wr_move,
  input  logic               wr_ready,
  output logic [STATE_W-1:0] state,
  output logic               busy,
  output logic               halted,
  output logic               timeout,
  output logic [CNT_W-1:0]   step_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [STATE_W-1:0] START_S = STATE_W'(START_STATE);
  localparam logic [CNT_W-1:0]   MAX_CNT = CNT_W'(MAX_STEPS);
  localparam logic [ENTRY_W-1:0] HALT_E  = {1'b1, {(ENTRY_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_ISSUE,
    S_HALT,
    S_TIMEOUT
  } fsm_t;

  fsm_t fsm;

  logic [ENTRY_W-1:0] table_q [DEPTH];
  logic [ENTRY_W-1:0] entry;
  logic [STATE_W-1:0] next_q;
  logic [CNT_W-1:0]   cnt_inc;
  logic               accept;

  assign entry   = table_q[{state, rd_sym}];
  assign cnt_inc = step_count + 1'b1;
  assign accept  = (fsm == S_IDLE) || (fsm == S_HALT) ||
                   (fsm == S_TIMEOUT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm        <= S_IDLE;
      state      <= START_S;
      step_count <= '0;
      wr_valid   <= 1'b0;
      wr_sym     <= '0;
      wr_move    <= 1'b0;
      next_q     <= '0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      timeout    <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        table_q[i] <= HALT_E;
    end else begin
      if (accept && cfg_we)
        table_q[cfg_addr] <= cfg_data;
      unique case (1'b1)
        accept: begin
          if (start) begin
            fsm        <= S_READ;
            state      <= START_S;
            step_count <= '0;
            busy       <= 1'b1;
            halted     <= 1'b0;
            timeout    <= 1'b0;
          end
        end
        fsm == S_READ: begin
          if (rd_valid) begin
            if (entry[ENTRY_W-1]) begin
              fsm    <= S_HALT;
              busy   <= 1'b0;
              halted <= 1'b1;
            end else begin
              fsm      <= S_ISSUE;
              wr_valid <= 1'b1;
              wr_move  <= entry[ENTRY_W-2];
              wr_sym   <= entry[STATE_W +: SYM_W];
              next_q   <= entry[STATE_W-1:0];
            end
          end
        end
        fsm == S_ISSUE: begin
          if (wr_ready) begin
            wr_valid   <= 1'b0;
            state      <= next_q;
            step_count <= cnt_inc;
            if (cnt_inc == MAX_CNT) begin
              fsm     <= S_TIMEOUT;
              busy    <= 1'b0;
              timeout <= 1'b1;
            end else begin
              fsm <= S_READ;
            end
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule
